// File: rtl/autoconfig_zii_chain.sv
// Zorro II AutoConfig responder presenting NUM_BOARDS logical boards, one
// after another, in $E80000 space. Boards whose jumper (BOARD_EN) is off are
// skipped. Each board can be assigned a base or shut up. CFGOUT_n is released
// to the next card only after the last board has been resolved.
// Optional feature macro: AC_ROMVEC_EN (diag ROM flag and vector for boards
// selected by ROM_MASK).
module autoconfig_zii_chain #(
    parameter int                      NUM_BOARDS  = 2,
    parameter logic [15:0]             MANUF_ID    = 16'h082C,
    parameter logic [31:0]             SERIAL      = 32'h0,
    parameter logic [8*NUM_BOARDS-1:0] PROD_IDS    = {8'h02, 8'h01},
    parameter logic [3*NUM_BOARDS-1:0] SIZE_CODES  = {3'b000, 3'b100},
    parameter logic [NUM_BOARDS-1:0]   LINK_MASK   = 2'b01,
    parameter logic [NUM_BOARDS-1:0]   ROM_MASK    = 2'b10,
    parameter logic [15:0]             DIAG_OFFSET = 16'h0000
) (
    input  logic                      C7M,
    input  logic                      RESET_n,
    input  logic                      CFGIN_n,
    input  logic                      AS_CPU_n,
    input  logic                      DS_n,
    input  logic                      RW_n,
    input  logic [7:0]                A_HIGH,
    input  logic [5:0]                A_LOW,
    input  logic [3:0]                D_IN,
    input  logic [NUM_BOARDS-1:0]     BOARD_EN,
    output logic [3:0]                D_OUT,
    output logic                      D_OE,
    output logic [8*NUM_BOARDS-1:0]   BASE,
    output logic [NUM_BOARDS-1:0]     CONFIGURED_n,
    output logic                      CFGOUT_n
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_BOARDS - 1);

    // Register offsets as seen on A[6:1] (byte offset / 2).
    localparam logic [5:0] REG_BASE_HI = 6'h24;
    localparam logic [5:0] REG_BASE_LO = 6'h25;
    localparam logic [5:0] REG_SHUTUP  = 6'h26;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SKIP,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t      state, state_next;
    logic [1:0]  idx, idx_next;
    logic [3:0]  base_latch;
    logic        wr_done;
    logic        sel;
    logic        wr_fire;
    logic        do_latch;
    logic        do_assign;
    logic        do_advance;
    logic [7:0]  cur_prod;
    logic [2:0]  cur_size;
    logic        cur_link;
    logic        cur_en;
    logic        cur_rom;
    logic        rom_flag;
    logic [3:0]  rd_nyb;

    assign sel     = (A_HIGH == 8'hE8) & ~AS_CPU_n & ~CFGIN_n & (state == ST_ACTIVE);
    assign wr_fire = sel & ~RW_n & ~DS_n & ~wr_done;
    assign D_OE    = sel & RW_n;
    assign D_OUT   = D_OE ? rd_nyb : 4'hF;

`ifdef AC_ROMVEC_EN
    assign rom_flag = cur_rom;
`else
    logic unused_rom_cfg;
    assign unused_rom_cfg = ^{ROM_MASK, DIAG_OFFSET, cur_rom};
    assign rom_flag       = 1'b0;
`endif

    // Select the parameter slice of the board currently being presented.
    always_comb begin
        cur_prod = 8'h00;
        cur_size = 3'b000;
        cur_link = 1'b0;
        cur_en   = 1'b0;
        cur_rom  = 1'b0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (idx == i[1:0]) begin
                cur_prod = PROD_IDS[i*8 +: 8];
                cur_size = SIZE_CODES[i*3 +: 3];
                cur_link = LINK_MASK[i];
                cur_en   = BOARD_EN[i];
                cur_rom  = ROM_MASK[i];
            end
        end
    end

    // Read nybble for the selected register; everything but $00/$02/$40/$42 is inverted.
    always_comb begin
        rd_nyb = 4'hF;
        case (A_LOW)
            6'd0:  rd_nyb = {2'b11, cur_link, rom_flag};
            6'd1:  rd_nyb = {1'b0, cur_size};
            6'd2:  rd_nyb = ~cur_prod[7:4];
            6'd3:  rd_nyb = ~cur_prod[3:0];
            6'd4:  rd_nyb = ~4'b1000;
            6'd8:  rd_nyb = ~MANUF_ID[15:12];
            6'd9:  rd_nyb = ~MANUF_ID[11:8];
            6'd10: rd_nyb = ~MANUF_ID[7:4];
            6'd11: rd_nyb = ~MANUF_ID[3:0];
            6'd12: rd_nyb = ~SERIAL[31:28];
            6'd13: rd_nyb = ~SERIAL[27:24];
            6'd14: rd_nyb = ~SERIAL[23:20];
            6'd15: rd_nyb = ~SERIAL[19:16];
            6'd16: rd_nyb = ~SERIAL[15:12];
            6'd17: rd_nyb = ~SERIAL[11:8];
            6'd18: rd_nyb = ~SERIAL[7:4];
            6'd19: rd_nyb = ~SERIAL[3:0];
`ifdef AC_ROMVEC_EN
            6'd20: rd_nyb = cur_rom ? ~DIAG_OFFSET[15:12] : 4'hF;
            6'd21: rd_nyb = cur_rom ? ~DIAG_OFFSET[11:8]  : 4'hF;
            6'd22: rd_nyb = cur_rom ? ~DIAG_OFFSET[7:4]   : 4'hF;
            6'd23: rd_nyb = cur_rom ? ~DIAG_OFFSET[3:0]   : 4'hF;
`endif
            6'd32: rd_nyb = 4'h0;
            6'd33: rd_nyb = 4'h0;
            default: rd_nyb = 4'hF;
        endcase
    end

    // Chain sequencing: wait for CFGIN_n, skip absent boards, decode writes, advance.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        do_latch   = 1'b0;
        do_assign  = 1'b0;
        do_advance = 1'b0;
        case (state)
            ST_WAIT: begin
                if (!CFGIN_n) state_next = ST_SKIP;
            end
            ST_SKIP: begin
                if (cur_en) state_next = ST_ACTIVE;
                else        do_advance = 1'b1;
            end
            ST_ACTIVE: begin
                if (wr_fire) begin
                    case (A_LOW)
                        REG_BASE_LO: do_latch = 1'b1;
                        REG_BASE_HI: begin
                            do_assign  = 1'b1;
                            do_advance = 1'b1;
                        end
                        REG_SHUTUP:  do_advance = 1'b1;
                        default:     ;
                    endcase
                end
            end
            ST_DONE: ;
            default: state_next = ST_WAIT;
        endcase
        if (do_advance) begin
            if (idx == LAST_IDX) begin
                state_next = ST_DONE;
            end else begin
                idx_next   = idx + 2'd1;
                state_next = ST_SKIP;
            end
        end
    end

    // State and board index registers.
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= ST_WAIT;
            idx   <= 2'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // One commit per bus cycle: the done flag holds off repeats until AS_CPU_n rises.
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n)      wr_done <= 1'b0;
        else if (AS_CPU_n) wr_done <= 1'b0;
        else if (wr_fire)  wr_done <= 1'b1;
    end

    // Base low-nybble latch, cleared whenever the chain moves to another board.
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n)        base_latch <= 4'h0;
        else if (do_advance) base_latch <= 4'h0;
        else if (do_latch)   base_latch <= D_IN;
    end

    // Record the assigned base and configured flag for the current board.
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            BASE         <= '0;
            CONFIGURED_n <= '1;
        end else if (do_assign) begin
            for (int i = 0; i < NUM_BOARDS; i++) begin
                if (idx == i[1:0]) begin
                    BASE[i*8 +: 8]  <= {D_IN, base_latch};
                    CONFIGURED_n[i] <= 1'b0;
                end
            end
        end
    end

    // Release the downstream chain one edge after the last board resolves.
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n)               CFGOUT_n <= 1'b1;
        else if (state == ST_DONE)  CFGOUT_n <= 1'b0;
    end

endmodule

// File: tb/tb_autoconfig_zii_chain.sv
// Directed bench for autoconfig_zii_chain: reset state, register reads,
// base assignment, shut-up, board skip, write-once guard, freeze and reset.
module tb_autoconfig_zii_chain;

    logic        C7M = 1'b0;
    logic        RESET_n = 1'b0;
    logic        CFGIN_n = 1'b1;
    logic        AS_CPU_n = 1'b1;
    logic        DS_n = 1'b1;
    logic        RW_n = 1'b1;
    logic [7:0]  A_HIGH = 8'h00;
    logic [5:0]  A_LOW = 6'h00;
    logic [3:0]  D_IN = 4'h0;
    logic [1:0]  BOARD_EN = 2'b11;
    logic [3:0]  D_OUT;
    logic        D_OE;
    logic [15:0] BASE;
    logic [1:0]  CONFIGURED_n;
    logic        CFGOUT_n;

    int checks = 0;
    int failures = 0;

`ifdef AC_ROMVEC_EN
    localparam logic [3:0] EXP_B1_00 = 4'hD;
    localparam logic [3:0] EXP_B1_2C = 4'hB;
`else
    localparam logic [3:0] EXP_B1_00 = 4'hC;
    localparam logic [3:0] EXP_B1_2C = 4'hF;
`endif

    autoconfig_zii_chain #(
        .DIAG_OFFSET(16'h0040)
    ) dut (
        .C7M(C7M),
        .RESET_n(RESET_n),
        .CFGIN_n(CFGIN_n),
        .AS_CPU_n(AS_CPU_n),
        .DS_n(DS_n),
        .RW_n(RW_n),
        .A_HIGH(A_HIGH),
        .A_LOW(A_LOW),
        .D_IN(D_IN),
        .BOARD_EN(BOARD_EN),
        .D_OUT(D_OUT),
        .D_OE(D_OE),
        .BASE(BASE),
        .CONFIGURED_n(CONFIGURED_n),
        .CFGOUT_n(CFGOUT_n)
    );

    always #10 C7M = ~C7M;

    task automatic wait_clocks(input int n);
        repeat (n) @(negedge C7M);
    endtask

    task automatic apply_reset(input logic [1:0] en);
        @(negedge C7M);
        RESET_n = 1'b0; AS_CPU_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
        CFGIN_n = 1'b0; BOARD_EN = en;
        wait_clocks(2);
        RESET_n = 1'b1;
        wait_clocks(4);
    endtask

    task automatic bus_read(input logic [7:0] ah, input logic [5:0] a,
                            output logic [3:0] d, output logic oe);
        @(negedge C7M);
        A_HIGH = ah; A_LOW = a; RW_n = 1'b1; AS_CPU_n = 1'b0; DS_n = 1'b0;
        @(posedge C7M);
        #1;
        d = D_OUT; oe = D_OE;
        @(negedge C7M);
        AS_CPU_n = 1'b1; DS_n = 1'b1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [3:0] v, input int hold);
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = a; D_IN = v; RW_n = 1'b0; AS_CPU_n = 1'b0; DS_n = 1'b0;
        wait_clocks(hold);
        AS_CPU_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
        wait_clocks(3);
    endtask

    task automatic test_reset();
        @(negedge C7M);
        RESET_n = 1'b0;
        #1;
        checks++;
        if ({D_OE, D_OUT, BASE, CONFIGURED_n, CFGOUT_n} !== {1'b0, 4'hF, 16'h0000, 2'b11, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_state got oe=%b d=%h base=%h cfg=%b cout=%b want oe=0 d=f base=0000 cfg=11 cout=1",
                     D_OE, D_OUT, BASE, CONFIGURED_n, CFGOUT_n);
        end
        apply_reset(2'b11);
    endtask

    task automatic test_board0_reads();
        logic [3:0] d;
        logic       oe;
        logic [5:0] addrs [11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd8, 6'd9, 6'd10, 6'd11, 6'd32, 6'd39};
        logic [3:0] exps  [11] = '{4'hE, 4'h4, 4'hF, 4'hE, 4'h7, 4'hF, 4'h7, 4'hD, 4'h3, 4'h0, 4'hF};
        for (int i = 0; i < 11; i++) begin
            bus_read(8'hE8, addrs[i], d, oe);
            checks++;
            if (d !== exps[i] || oe !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b0_read a=%0d got d=%h oe=%b want d=%h oe=1", addrs[i], d, oe, exps[i]);
            end
        end
        bus_read(8'hE9, 6'd0, d, oe);
        checks++;
        if (oe !== 1'b0 || d !== 4'hF) begin
            failures++;
            $display("[TB] FAIL wrong_space got d=%h oe=%b want d=f oe=0", d, oe);
        end
        checks++;
        if (CFGOUT_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cfgout_early got %b want 1", CFGOUT_n);
        end
    endtask

    task automatic test_assign();
        logic [3:0] d;
        logic       oe;
        bus_write(6'h25, 4'h0, 1);
        bus_write(6'h24, 4'h2, 1);
        checks++;
        if (BASE !== 16'h0020 || CONFIGURED_n !== 2'b10) begin
            failures++;
            $display("[TB] FAIL assign_b0 got base=%h cfg=%b want base=0020 cfg=10", BASE, CONFIGURED_n);
        end
        bus_read(8'hE8, 6'd1, d, oe);
        checks++;
        if (d !== 4'h0 || oe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b1_size got d=%h oe=%b want d=0 oe=1", d, oe);
        end
        bus_read(8'hE8, 6'd0, d, oe);
        checks++;
        if (d !== EXP_B1_00) begin
            failures++;
            $display("[TB] FAIL b1_type got %h want %h", d, EXP_B1_00);
        end
        bus_read(8'hE8, 6'd22, d, oe);
        checks++;
        if (d !== EXP_B1_2C) begin
            failures++;
            $display("[TB] FAIL b1_diag2c got %h want %h", d, EXP_B1_2C);
        end
        bus_read(8'hE8, 6'd20, d, oe);
        checks++;
        if (d !== 4'hF) begin
            failures++;
            $display("[TB] FAIL b1_diag28 got %h want f", d);
        end
        bus_read(8'hE8, 6'h24, d, oe);
        checks++;
        if (CONFIGURED_n !== 2'b10 || d !== 4'hF) begin
            failures++;
            $display("[TB] FAIL read_no_change got cfg=%b d=%h want cfg=10 d=f", CONFIGURED_n, d);
        end
    endtask

    task automatic test_as_before_ds();
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = 6'h26; RW_n = 1'b0; AS_CPU_n = 1'b0; DS_n = 1'b1;
        wait_clocks(2);
        AS_CPU_n = 1'b1;
        wait_clocks(1);
        DS_n = 1'b0;
        wait_clocks(1);
        DS_n = 1'b1; RW_n = 1'b1;
        wait_clocks(2);
        checks++;
        if (CFGOUT_n !== 1'b1 || CONFIGURED_n !== 2'b10) begin
            failures++;
            $display("[TB] FAIL as_before_ds got cout=%b cfg=%b want cout=1 cfg=10", CFGOUT_n, CONFIGURED_n);
        end
    endtask

    task automatic test_freeze();
        logic [3:0] d;
        logic       oe;
        @(negedge C7M);
        CFGIN_n = 1'b1;
        bus_read(8'hE8, 6'd0, d, oe);
        checks++;
        if (oe !== 1'b0 || d !== 4'hF) begin
            failures++;
            $display("[TB] FAIL freeze got d=%h oe=%b want d=f oe=0", d, oe);
        end
        CFGIN_n = 1'b0;
        bus_read(8'hE8, 6'd1, d, oe);
        checks++;
        if (oe !== 1'b1 || d !== 4'h0) begin
            failures++;
            $display("[TB] FAIL resume got d=%h oe=%b want d=0 oe=1", d, oe);
        end
    endtask

    task automatic test_shutup();
        logic [3:0] d;
        logic       oe;
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = 6'h26; RW_n = 1'b0; AS_CPU_n = 1'b0; DS_n = 1'b0;
        @(posedge C7M);
        #1;
        checks++;
        if (CFGOUT_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cfgout_commit_edge got %b want 1", CFGOUT_n);
        end
        @(posedge C7M);
        #1;
        checks++;
        if (CFGOUT_n !== 1'b0 || CONFIGURED_n !== 2'b10) begin
            failures++;
            $display("[TB] FAIL shutup got cout=%b cfg=%b want cout=0 cfg=10", CFGOUT_n, CONFIGURED_n);
        end
        @(negedge C7M);
        AS_CPU_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
        bus_read(8'hE8, 6'd0, d, oe);
        checks++;
        if (oe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_no_oe got oe=%b want 0", oe);
        end
    endtask

    task automatic test_skip();
        logic [3:0] d;
        logic       oe;
        apply_reset(2'b10);
        bus_read(8'hE8, 6'd0, d, oe);
        checks++;
        if (d !== EXP_B1_00 || oe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL skip_first got d=%h oe=%b want d=%h oe=1", d, oe, EXP_B1_00);
        end
        bus_write(6'h25, 4'h5, 1);
        bus_write(6'h24, 4'h3, 1);
        checks++;
        if (BASE !== 16'h3500 || CONFIGURED_n !== 2'b01 || CFGOUT_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL skip_assign got base=%h cfg=%b cout=%b want base=3500 cfg=01 cout=0",
                     BASE, CONFIGURED_n, CFGOUT_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        logic       oe;
        apply_reset(2'b11);
        bus_write(6'h24, 4'h4, 6);
        checks++;
        if (BASE !== 16'h0040 || CONFIGURED_n !== 2'b10 || CFGOUT_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL held_ds got base=%h cfg=%b cout=%b want base=0040 cfg=10 cout=1",
                     BASE, CONFIGURED_n, CFGOUT_n);
        end
        bus_read(8'hE8, 6'd1, d, oe);
        checks++;
        if (d !== 4'h0 || oe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL held_ds_board got d=%h oe=%b want d=0 oe=1", d, oe);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = 6'h24; D_IN = 4'h9; RW_n = 1'b0; AS_CPU_n = 1'b0; DS_n = 1'b0;
        #5;
        RESET_n = 1'b0;
        #1;
        checks++;
        if ({D_OE, D_OUT, BASE, CONFIGURED_n, CFGOUT_n} !== {1'b0, 4'hF, 16'h0000, 2'b11, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_mid_write got oe=%b d=%h base=%h cfg=%b cout=%b want oe=0 d=f base=0000 cfg=11 cout=1",
                     D_OE, D_OUT, BASE, CONFIGURED_n, CFGOUT_n);
        end
        AS_CPU_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
        apply_reset(2'b11);
    endtask

    initial begin
        test_reset();
        test_board0_reads();
        test_assign();
        test_as_before_ds();
        test_freeze();
        test_shutup();
        test_skip();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
